// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the switch debouncer.
// The optional long-press detector is enabled with the LONG_PRESS_EN macro.
package sw_debounce_pkg;

  typedef enum logic [1:0] {S_LO, S_WAIT_HI, S_HI, S_WAIT_LO} deb_state_t;

  // Converts a duration in milliseconds to a terminal count (cycles - 1).
  function automatic int ms_to_cycles(input int freq_hz, input int ms);
    return freq_hz / 1000 * ms - 1;
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: synchronizer, four-state timed FSM and registered pulses.
// With LONG_PRESS_EN defined, a hold counter adds a single long-press pulse per press.
module sw_debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_MS     = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
`ifdef LONG_PRESS_EN
  ,
  output logic sw_long
`endif
);

  localparam int CNT_MAX = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int LCNT    = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
  localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

  if (CNT_MAX < 1) begin : g_bad_cnt
    $error("sw_debounce_chan: debounce time must be at least two clock cycles");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sw_debounce_chan: SYNC_STAGES must be at least 2");
  end
  if (LCNT < 0) begin : g_bad_long
    $error("sw_debounce_chan: LONG_MS must be at least one clock cycle");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sw_s;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sw_s = sync_p0[SYNC_STAGES-1];

  // Stage p0: synchronizer; stage p1: FSM, counter and output registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LO: if (sw_s) begin
        state_d = S_WAIT_HI;
        cnt_d   = '0;
      end
      S_WAIT_HI: if (!sw_s) begin
        state_d = S_LO;
        cnt_d   = '0;
      end else if (cnt_q == CNT_MAX_C) begin
        state_d = S_HI;
        cnt_d   = '0;
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_HI: if (!sw_s) begin
        state_d = S_WAIT_LO;
        cnt_d   = '0;
      end
      S_WAIT_LO: if (sw_s) begin
        state_d = S_HI;
        cnt_d   = '0;
      end else if (cnt_q == CNT_MAX_C) begin
        state_d = S_LO;
        cnt_d   = '0;
        level_d = 1'b0;
        fall_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sw_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

`ifdef LONG_PRESS_EN
  localparam int LCNT_W = (LCNT < 1) ? 1 : $clog2(LCNT + 1);
  localparam logic [LCNT_W-1:0] LCNT_C = LCNT_W'(LCNT);

  logic [LCNT_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              long_q, long_d;

  // The counter freezes at its terminal value; fired_q limits it to one pulse per press.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (state_q == S_HI || state_q == S_WAIT_LO) begin
      if (hold_q != LCNT_C) begin
        hold_d = hold_q + LCNT_W'(1);
      end else if (!fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end else begin
      hold_d  = '0;
      fired_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign sw_long = long_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// N_CH independent switch debouncers producing clean levels and edge pulses.
// Define LONG_PRESS_EN to add the sw_long long-press pulse outputs.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_MS     = 1000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_level,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
`ifdef LONG_PRESS_EN
  ,
  output logic [N_CH-1:0] sw_long
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce_chan #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_MS    (LONG_MS)
    ) u_chan (
      .CLK     (CLK),
      .RST     (RST),
      .sw_raw  (sw_raw[i]),
      .sw_level(sw_level[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
`ifdef LONG_PRESS_EN
      ,
      .sw_long (sw_long[i])
`endif
    );
  end

endmodule
